// File: rtl/orb_frame_reader_if.sv
// rtl/orb_frame_reader_if.sv - frame-buffer read port and page-swap line between reader and RAM/filler
interface orb_frame_reader_if #(
    parameter int IDX_W  = 10,
    parameter int DATA_W = 12
);
    logic [IDX_W:0]    rdAddr;
    logic [DATA_W-1:0] rdData;
    logic              nowRead;
    logic              orbSwitch;

    modport master (
        output rdAddr,
        output nowRead,
        output orbSwitch,
        input  rdData
    );

    modport slave (
        input  rdAddr,
        input  nowRead,
        input  orbSwitch,
        output rdData
    );
endinterface

// File: rtl/orb_frame_reader.sv
// rtl/orb_frame_reader.sv - ping-pong frame buffer reader, serialises 12-bit words MSB-first as NRZ
module orb_frame_reader #(
    parameter int BIT_DIV = 80,
    parameter int RD_LAT  = 2,
    parameter int WORDS   = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run_i,
    orb_frame_reader_if.master bus,
    output logic               serOut_o,
    output logic               bitStrobe_o,
    output logic               wordSync_o,
    output logic               frameSync_o,
    output logic               streaming_o
);
    localparam int IDX_W = $clog2(WORDS);
    localparam int DIV_W = 12;

    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(BIT_DIV - 1);
    localparam logic [IDX_W-1:0] WORD_LAST = IDX_W'(WORDS - 1);
    localparam logic [1:0]       LAT_LAST  = 2'(RD_LAT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_PRIME,
        S_SHIFT,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             page_q, page_d;
    logic [IDX_W-1:0] word_q, word_d;
    logic [IDX_W:0]   addr_q, addr_d;
    logic             rd_q, rd_d;
    logic [1:0]       lat_q, lat_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [3:0]       bit_q, bit_d;
    logic [11:0]      shift_q, shift_d;
    logic [11:0]      next_q, next_d;
    logic             strobe_q, wsync_q, fsync_q, stream_q;
    logic             word_start;

    always_comb begin
        state_d    = state_q;
        page_d     = page_q;
        word_d     = word_q;
        addr_d     = addr_q;
        rd_d       = rd_q;
        lat_d      = lat_q;
        div_d      = div_q;
        bit_d      = bit_q;
        shift_d    = shift_q;
        next_d     = next_q;
        word_start = 1'b0;

        // An outstanding read lands in shift_q while priming, otherwise in next_q.
        if (rd_q) begin
            if (lat_q == LAT_LAST) begin
                rd_d = 1'b0;
                if (state_q == S_PRIME) begin
                    shift_d = bus.rdData;
                end else begin
                    next_d = bus.rdData;
                end
            end else begin
                lat_d = lat_q + 2'd1;
            end
        end

        unique case (state_q)
            S_IDLE: begin
                if (run_i) begin
                    state_d = S_PRIME;
                    addr_d  = {page_q, {IDX_W{1'b0}}};
                    rd_d    = 1'b1;
                    lat_d   = 2'd0;
                end
            end
            S_PRIME: begin
                if (rd_q && lat_q == LAT_LAST) begin
                    state_d    = S_SHIFT;
                    div_d      = '0;
                    bit_d      = 4'd11;
                    word_start = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == DIV_LAST) begin
                    div_d = '0;
                    if (bit_q == 4'd0) begin
                        shift_d = next_q;
                        bit_d   = 4'd11;
                        word_d  = word_q + 1'b1;
                        // Frame boundary: release the page to the filler; run only matters here.
                        if (word_q == WORD_LAST) begin
                            page_d = ~page_q;
                            if (!run_i) begin
                                state_d = S_STOP;
                                shift_d = '0;
                            end
                        end
                        word_start = (state_d == S_SHIFT);
                    end else begin
                        shift_d = {shift_q[10:0], 1'b0};
                        bit_d   = bit_q - 4'd1;
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            S_STOP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Prefetch the following word while bit 11 of this one is on the line.
        if (word_start) begin
            rd_d  = 1'b1;
            lat_d = 2'd0;
            if (word_d == WORD_LAST) begin
                addr_d = {~page_d, {IDX_W{1'b0}}};
            end else begin
                addr_d = {page_d, word_d + 1'b1};
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            page_q   <= 1'b0;
            word_q   <= '0;
            addr_q   <= '0;
            rd_q     <= 1'b0;
            lat_q    <= 2'd0;
            div_q    <= '0;
            bit_q    <= 4'd0;
            shift_q  <= '0;
            next_q   <= '0;
            strobe_q <= 1'b0;
            wsync_q  <= 1'b0;
            fsync_q  <= 1'b0;
            stream_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            page_q   <= page_d;
            word_q   <= word_d;
            addr_q   <= addr_d;
            rd_q     <= rd_d;
            lat_q    <= lat_d;
            div_q    <= div_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            next_q   <= next_d;
            strobe_q <= (state_d == S_SHIFT) && (div_d == '0);
            wsync_q  <= (state_d == S_SHIFT) && (bit_d == 4'd11);
            fsync_q  <= (state_d == S_SHIFT) && (word_d == '0);
            stream_q <= (state_d == S_SHIFT);
        end
    end

    assign bus.rdAddr    = addr_q;
    assign bus.nowRead   = rd_q;
    assign bus.orbSwitch = ~page_q;
    assign serOut_o      = shift_q[11];
    assign bitStrobe_o   = strobe_q;
    assign wordSync_o    = wsync_q;
    assign frameSync_o   = fsync_q;
    assign streaming_o   = stream_q;
endmodule

// File: doc/orb_frame_reader.md
Name: orb_frame_reader

Overview:
- Downstream consumer of the ping-pong frame buffer that the frame filler writes.
- Reads 1024 x 12-bit words from the page the filler is not writing and serialises them MSB-first as a gapless NRZ telemetry bitstream.
- Toggles the page-swap line (orbSwitch) at every frame boundary so the filler refills the page just released.
- Drives nowRead while a buffer read is in flight.

Parameters:
- BIT_DIV, 80, clk cycles per serial bit (80 MHz clk -> 1 Mbit/s); legal range RD_LAT+3 .. 4095.
- RD_LAT, 2, RAM read latency in clk cycles from rdAddr change to valid rdData; legal range 1..3.
- WORDS, 1024, words per frame (power of two, matches filler address space).

Ports:
- clk  in  1  system clock, 80 MHz.
- reset  in  1  asynchronous, active-low reset.
- run  in  1  stream enable, level; sampled only in IDLE and at frame boundaries.
- rdData  in  12  RAM read-port data.
- rdAddr  out  11  RAM read address {page, wordIdx[9:0]}.
- nowRead  out  1  high from read issue until rdData is captured.
- orbSwitch  out  1  page-swap line to filler; always equals ~page (filler writes page ~page).
- serOut  out  1  serial data, MSB of word first.
- bitStrobe  out  1  one-clk pulse on the first clk of every bit period.
- wordSync  out  1  high for the whole bit period of bit 11 of every word.
- frameSync  out  1  high for the whole duration of word 0 of every frame.
- streaming  out  1  high while in SHIFT.

Behaviour:
- Reset (async, any state): state=IDLE, page=0, wordIdx=0, rdAddr=0, nowRead=0, orbSwitch=1, serOut=0, bitStrobe=0, wordSync=0, frameSync=0, streaming=0, divCnt=0, bitCnt=0, shift and next registers=0.
- orbSwitch=1 from reset is intentional: the filler's edge detector (reset 0) sees a change and fills page 1 immediately.
- States: IDLE, PRIME, SHIFT, STOP.
- IDLE:
  - outputs low.
  - run=1 -> PRIME.
  - rdAddr={page,0}; nowRead=1 for RD_LAT cycles; then shiftReg<=rdData, bitCnt=11, divCnt=0 -> SHIFT.
- SHIFT:
  - serOut=shiftReg[11].
  - divCnt counts 0..BIT_DIV-1; bitStrobe=1 when divCnt==0.
  - At divCnt==BIT_DIV-1: shift left one and decrement bitCnt.
  - Prefetch: at divCnt==0 of bit 11, set rdAddr to the next word's address and nowRead=1. Capture rdData into nextReg exactly RD_LAT clks later, then nowRead=0.
  - End of bit 0 (bitCnt==0, divCnt==BIT_DIV-1): shiftReg<=nextReg, bitCnt<=11, wordIdx+1. No idle clk between words.
  - Each word occupies exactly 12*BIT_DIV clks.
- Frame boundary, when wordIdx==WORDS-1 completes:
  - wordIdx wraps to 0; page toggles; orbSwitch toggles on the same clk.
  - The prefetch issued during bit 11 of word WORDS-1 uses {~page,0}, i.e. it already targets the new page.
  - If run=0 at this boundary -> STOP; otherwise stay in SHIFT.
- STOP: serOut=0, streaming=0, one clk, -> IDLE. The page has already toggled.
- run deasserted mid-frame is ignored until the boundary. The frame always completes.
- The first frame after reset streams page 0, which has not been written. Its contents are undefined, and this is accepted.
- rdAddr holds its last value when not reading.

Test Plan:
- Reset with BIT_DIV=4, RD_LAT=2; RAM page0[i]=i, page1[i]=12'h800|i; release reset, run=1. Required:
  - orbSwitch=1 from reset.
  - serOut word0 = 000000000000.
  - bitStrobe every 4 clks.
  - wordSync during the bit-11 period; frameSync during word 0.
  - Word1 = 000000000001, starting exactly 48 clks after word0.
- Full frame: after 1024 words (49152 clks at BIT_DIV=4), orbSwitch toggles to 0, page=1, first serialised word = 12'h800, and there is no gap at the boundary.
- Prefetch timing: nowRead high for exactly RD_LAT=2 clks starting at the bit-11 strobe. rdAddr = {page, wordIdx+1}; at word 1023 it is {~page,0}.
- run dropped at word 500 -> streaming continues to word 1023, orbSwitch toggles, STOP, IDLE. run reasserted -> PRIME reads {1,0}, and streaming resumes with 12'h800 after RD_LAT+1 clks.
- Async reset asserted mid-bit in word 37 -> all outputs reach their reset values immediately (orbSwitch=1). After release, streaming restarts from {0,0}.
- Data pattern 12'hA5C -> serOut bits 1,0,1,0,0,1,0,1,1,1,0,0, each held BIT_DIV clks.
